fir_accum_stage: RTL and testbench
==================================

Name: fir_accum_stage

Overview:
Accumulator stage directly downstream of the 16-bit Han-Carlson prefix adder in the FIR datapath. It consumes one adder sum per valid/ready beat and sign-extends each sum. It accumulates TAPS consecutive beats into one filter output sample, then presents that sample on a registered valid/ready output. It also exports the running tap index so upstream coefficient/delay-line logic can address the current tap.

Parameters:
DW, 16, width of incoming adder sum (two's complement)
ACCW, 24, accumulator and output width; must be >= DW+1
TAPS, 8, beats accumulated per output sample; power of 2, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous frame abort/clear
in_valid  input  1  upstream sum valid
in_ready  output  1  stage can accept a sum
in_data  input  DW  adder sum, signed two's complement
tap_idx  output  $clog2(TAPS)  index of the next beat to be accepted (0..TAPS-1)
out_valid  output  1  accumulated sample valid
out_ready  input  1  downstream accepts sample
out_data  output  ACCW  accumulated sample, signed
out_ovf  output  1  overflow/saturation flag for this sample

Behaviour:
- Reset (rst_n low, asynchronous): state=ACC, tap_idx=0, acc=0, out_valid=0, out_data=0, out_ovf=0. in_ready is decoded from state, so it reads 1 during reset.
- States:
  - ACC: in_ready=1.
  - DONE: in_ready=0, out_valid=1.
- Accept = in_valid && in_ready.
  - On accept with tap_idx==0: acc <= sext(in_data).
  - On accept with tap_idx!=0: acc <= acc + sext(in_data).
  - Every accept increments tap_idx; it wraps TAPS-1 -> 0.
- Accept with tap_idx==TAPS-1:
  - out_data <= final sum (acc + sext(in_data)), out_ovf <= frame flag, out_valid <= 1, state -> DONE.
  - Latency: out_valid rises on the clock edge that accepts the last beat, so it is visible in the following cycle.
- No accept (in_valid low in ACC): all state holds; gaps between beats are legal.
- DONE:
  - Holds out_data/out_ovf stable while out_ready=0.
  - On out_valid && out_ready: out_valid <= 0, state -> ACC.
  - in_ready returns to 1 in the next cycle; this one-cycle bubble per sample is mandatory and there is no bypass.
- Arithmetic: sign-extend DW -> ACCW. Default behaviour is modulo 2^ACCW wrap; see the optional feature for saturation.
- clr=1 (synchronous, highest priority over accept and output handshake):
  - state=ACC, tap_idx=0, acc=0, frame flag=0, out_valid=0.
  - out_data keeps its last value.
  - A beat presented in the same cycle as clr is dropped.
- Reset mid-frame: the partial sum is discarded; the first beat after reset is tap 0.
- in_data is sampled only on accept; X on in_data while in_valid=0 must not propagate.

Optional Feature:
Macro FIR_ACCUM_SAT_EN.
- Defined:
  - Each add saturates to +(2^(ACCW-1)-1) or -2^(ACCW-1).
  - A sticky frame flag is set on any saturating add within the frame.
  - The flag is copied to out_ovf with out_data and cleared at tap 0.
- Undefined:
  - Adds wrap modulo 2^ACCW.
  - out_ovf is tied to 0 and no saturation logic is present.

Test Plan:
1. Default params; reset, then 8 beats of 16'h0001 back-to-back, out_ready=1 -> in_ready=1 for 8 cycles; out_valid high 1 cycle after beat 8; out_data=24'h000008; tap_idx back to 0; in_ready=0 for exactly 1 cycle.
2. 8 beats of 16'hFFFF -> out_data=24'hFFFFF8, out_ovf=0. Then alternate 16'h0005/16'hFFFD for 8 beats -> 24'h000008.
3. Backpressure: complete a frame with out_ready=0 for 5 cycles -> out_valid, out_data and in_ready=0 held stable; a beat offered meanwhile is not accepted. Raise out_ready -> handshake; in_ready=1 next cycle; tap_idx=0.
4. clr after 3 beats of 16'h0100, with a 4th beat offered in the clr cycle -> that beat is dropped, tap_idx=0. A following frame of 8x16'h0002 gives out_data=24'h000010.
5. ACCW=17, 8x16'h7FFF:
   - FIR_ACCUM_SAT_EN defined -> out_data=17'h0FFFF, out_ovf=1.
   - FIR_ACCUM_SAT_EN undefined -> out_data=17'h1FFF8, out_ovf=0.
6. Assert rst_n low asynchronously mid-cycle after 5 beats -> out_valid, out_data and tap_idx go to 0 immediately. After release, 8x16'h0003 gives 24'h000018.

Source files
------------

// File: rtl/fir_accum_stage_if.sv
// Handshake bundle between the prefix-adder output, the accumulator stage and its consumer.
// The stage uses the slave modport; the upstream/downstream driver uses master.
interface fir_accum_stage_if #(
  parameter int DW   = 16,
  parameter int ACCW = 24,
  parameter int TAPS = 8
);
  localparam int TW = $clog2(TAPS);

  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [TW-1:0]   tap_idx;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_data;
  logic            out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, tap_idx, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, tap_idx, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/fir_accum_stage.sv
// FIR accumulator: sums TAPS sign-extended adder beats into one registered output sample.
// Define FIR_ACCUM_SAT_EN for saturating adds with a sticky per-frame overflow flag.
module fir_accum_stage #(
  parameter int DW   = 16,
  parameter int ACCW = 24,
  parameter int TAPS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  fir_accum_stage_if.slave bus
);
  // state   | meaning
  // ST_ACC  | accepting beats, accumulating the current frame
  // ST_DONE | sample presented, waiting for out_ready (one-cycle bubble minimum)

  localparam int TW = $clog2(TAPS);
  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);

  typedef enum logic {ST_ACC = 1'b0, ST_DONE = 1'b1} state_t;

  state_t          state, state_nxt;
  logic            in_rdy;
  logic            out_vld;
  logic [TW-1:0]   tap_idx;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] out_data;
  logic [ACCW-1:0] sext;
  logic [ACCW-1:0] add_res;
  logic            accept;
  logic            last_beat;
  logic            first_beat;

  assign sext       = {{(ACCW-DW){bus.in_data[DW-1]}}, bus.in_data};
  assign accept     = bus.in_valid && in_rdy;
  assign first_beat = (tap_idx == '0);
  assign last_beat  = accept && (tap_idx == LAST_TAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_ACC;
    end else begin
      case (state)
        ST_ACC:  if (last_beat)     state_nxt = ST_DONE;
        ST_DONE: if (bus.out_ready) state_nxt = ST_ACC;
        default: state_nxt = ST_ACC;
      endcase
    end
  end

  always_comb begin
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    case (state)
      ST_ACC:  in_rdy  = 1'b1;
      ST_DONE: out_vld = 1'b1;
      default: in_rdy  = 1'b1;
    endcase
  end

`ifdef FIR_ACCUM_SAT_EN
  localparam logic [ACCW-1:0] SAT_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] SAT_MIN = {1'b1, {(ACCW-1){1'b0}}};

  logic [ACCW:0] wide_sum;
  logic          sat_hit;
  logic          frame_ovf;
  logic          out_ovf;

  // One guard bit: the top two bits disagree exactly when the signed add overflowed.
  assign wide_sum = {acc[ACCW-1], acc} + {sext[ACCW-1], sext};
  assign sat_hit  = wide_sum[ACCW] ^ wide_sum[ACCW-1];
  assign add_res  = sat_hit ? (wide_sum[ACCW] ? SAT_MIN : SAT_MAX) : wide_sum[ACCW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ovf <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      frame_ovf <= 1'b0;
    end else if (accept) begin
      frame_ovf <= first_beat ? 1'b0 : (frame_ovf | sat_hit);
      if (last_beat) out_ovf <= frame_ovf | sat_hit;
    end
  end

  assign bus.out_ovf = out_ovf;
`else
  assign add_res     = acc + sext;
  assign bus.out_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_idx  <= '0;
      acc      <= '0;
      out_data <= '0;
    end else if (clr) begin
      tap_idx  <= '0;
      acc      <= '0;
    end else if (accept) begin
      tap_idx <= tap_idx + TW'(1);
      acc     <= first_beat ? sext : add_res;
      if (last_beat) out_data <= add_res;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.tap_idx   = tap_idx;
  assign bus.out_data  = out_data;
endmodule

// File: tb/tb_fir_accum_stage.sv
// Directed bench for fir_accum_stage: a 24-bit and a 17-bit instance share one stimulus stream.
module tb_fir_accum_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fir_accum_stage_if #(.DW(16), .ACCW(24), .TAPS(8)) bus ();
  fir_accum_stage_if #(.DW(16), .ACCW(17), .TAPS(8)) bus17 ();

  assign bus.in_valid    = in_valid;
  assign bus.in_data     = in_data;
  assign bus.out_ready   = out_ready;
  assign bus17.in_valid  = in_valid;
  assign bus17.in_data   = in_data;
  assign bus17.out_ready = out_ready;

  fir_accum_stage #(.DW(16), .ACCW(24), .TAPS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
  );

  fir_accum_stage #(.DW(16), .ACCW(17), .TAPS(8)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus17)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat for one clock; valid stays high so calls chain back-to-back.
  task automatic send_beat(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  task automatic send_frame(input logic [15:0] d);
    for (int i = 0; i < 8; i++) send_beat(d);
    in_valid = 1'b0;
    in_data  = 16'hxxxx;
  endtask

  initial begin
    int ready_cnt;

    // reset state
    #2;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_tap_idx",   32'(bus.tap_idx),   32'd0);
    check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
    step();
    rst_n = 1'b1;
    step();

    // test 1: eight ones back-to-back
    ready_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.in_ready) ready_cnt++;
      send_beat(16'h0001);
      if (i == 6) begin
        check("t1_tap_before_last", 32'(bus.tap_idx),   32'd7);
        check("t1_no_early_valid",  32'(bus.out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    in_data  = 16'hxxxx;
    check("t1_ready_cycles", 32'(ready_cnt),        32'd8);
    check("t1_out_valid",    32'(bus.out_valid),    32'd1);
    check("t1_out_data",     32'(bus.out_data),     32'h000008);
    check("t1_tap_wrap",     32'(bus.tap_idx),      32'd0);
    check("t1_bubble",       32'(bus.in_ready),     32'd0);
    check("t1_out_ovf",      32'(bus.out_ovf),      32'd0);
    step();
    check("t1_valid_drop",   32'(bus.out_valid),    32'd0);
    check("t1_ready_back",   32'(bus.in_ready),     32'd1);

    // test 2: negative ones, then alternating +5/-3
    send_frame(16'hFFFF);
    check("t2_neg_data", 32'(bus.out_data), 32'hFFFFF8);
    check("t2_neg_ovf",  32'(bus.out_ovf),  32'd0);
    step();
    for (int i = 0; i < 8; i++) send_beat((i % 2 == 0) ? 16'h0005 : 16'hFFFD);
    in_valid = 1'b0;
    check("t2_alt_data", 32'(bus.out_data), 32'h000008);
    step();

    // test 3: downstream backpressure
    out_ready = 1'b0;
    send_frame(16'h0010);
    in_valid = 1'b1;
    in_data  = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t3_hold_data",  32'(bus.out_data),  32'h000080);
      check("t3_hold_ready", 32'(bus.in_ready),  32'd0);
    end
    check("t3_hold_tap", 32'(bus.tap_idx), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("t3_hs_valid", 32'(bus.out_valid), 32'd0);
    check("t3_hs_ready", 32'(bus.in_ready),  32'd1);
    check("t3_hs_tap",   32'(bus.tap_idx),   32'd0);
    send_frame(16'h0001);
    check("t3_next_frame", 32'(bus.out_data), 32'h000008);
    step();

    // test 4: clr drops the partial frame and the beat offered with it
    for (int i = 0; i < 3; i++) send_beat(16'h0100);
    check("t4_tap_mid", 32'(bus.tap_idx), 32'd3);
    clr = 1'b1;
    send_beat(16'h0100);
    clr      = 1'b0;
    in_valid = 1'b0;
    check("t4_clr_tap",   32'(bus.tap_idx),   32'd0);
    check("t4_clr_valid", 32'(bus.out_valid), 32'd0);
    check("t4_keep_data", 32'(bus.out_data),  32'h000008);
    send_frame(16'h0002);
    check("t4_frame_data", 32'(bus.out_data), 32'h000010);
    step();

    // test 5: 17-bit instance overflows, 24-bit one does not
    send_frame(16'h7FFF);
    check("t5_wide_data", 32'(bus.out_data), 32'h03FFF8);
    check("t5_wide_ovf",  32'(bus.out_ovf),  32'd0);
`ifdef FIR_ACCUM_SAT_EN
    check("t5_narrow_data", 32'(bus17.out_data), 32'h0FFFF);
    check("t5_narrow_ovf",  32'(bus17.out_ovf),  32'd1);
`else
    check("t5_narrow_data", 32'(bus17.out_data), 32'h1FFF8);
    check("t5_narrow_ovf",  32'(bus17.out_ovf),  32'd0);
`endif
    step();
    send_frame(16'h0001);
    check("t5_flag_clear", 32'(bus17.out_ovf),  32'd0);
    check("t5_narrow_next", 32'(bus17.out_data), 32'h00008);
    step();

    // test 6: asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) send_beat(16'h0003);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_data",  32'(bus.out_data),  32'h0);
    check("t6_rst_tap",   32'(bus.tap_idx),   32'd0);
    step();
    #2;
    rst_n = 1'b1;
    step();
    send_frame(16'h0003);
    check("t6_frame_data", 32'(bus.out_data),  32'h000018);
    check("t6_frame_valid", 32'(bus.out_valid), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
